pio_event_master: RTL

Bus initiator that services a `pio_s` port window on the 8-bit IO bus. When the port's `int` line is high, it takes the bus, reads INTFLAGS and IN, writes the captured flags back to INTFLAGS (write-one-to-clear), and pushes a `{pins, flags}` event into a small FIFO. The FIFO is drained by the CPU or a DMA consumer over a valid/ready handshake. The block sits beside the CPU as a second master behind the IO bus arbiter.

---
 rtl/pio_event_master.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pio_event_master.sv
// pio_event_master: services a pio_s port window as a second IO bus master.
// On a port interrupt it reads INTFLAGS and IN, writes the flags back to
// clear them, and queues a {pins, flags} event for a valid/ready consumer.
module pio_event_master #(
  parameter int unsigned PORT_ADDRESS      = 0,
  parameter logic [4:0]  IN_OFFSET         = 5'h08,
  parameter logic [4:0]  INTFLAGS_OFFSET   = 5'h09,
  parameter int unsigned FIFO_DEPTH_LOG2   = 2,
  parameter int unsigned BUS_ADDR_DATA_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pio_int,
  output logic                         m_req,
  input  logic                         m_gnt,
  output logic [BUS_ADDR_DATA_LEN-1:0] m_addr,
  output logic                         m_wr,
  output logic                         m_rd,
  output logic [7:0]                   m_dout,
  input  logic [7:0]                   m_din,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [15:0]                  ev_data,
  output logic [FIFO_DEPTH_LOG2:0]     ev_count,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int unsigned AW    = BUS_ADDR_DATA_LEN;
  localparam int unsigned PW    = FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [AW-1:0] FLAGS_ADDR = AW'(PORT_ADDRESS + 32'(INTFLAGS_OFFSET));
  localparam logic [AW-1:0] IN_ADDR    = AW'(PORT_ADDRESS + 32'(IN_OFFSET));

  typedef struct packed {
    logic [7:0] pins;
    logic [7:0] flags;
  } pio_event_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_RD_FLAGS = 3'd2,
    S_RD_IN    = 3'd3,
    S_WR_CLR   = 3'd4,
    S_PUSH     = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0] flags_q;
  logic [7:0] pins_q;

  // Next-cycle bus values, registered onto the m_* ports
  logic          req_d;
  logic          rd_d;
  logic          wr_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    dout_d;

  // FIFO storage and bookkeeping
  pio_event_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  pio_event_t    push_data;
  pio_event_t    head_next;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero flag read means a spurious interrupt
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (pio_int) state_next = S_REQ;
      S_REQ:      if (m_gnt) state_next = S_RD_FLAGS;
      S_RD_FLAGS: state_next = (m_din == 8'h00) ? S_IDLE : S_RD_IN;
      S_RD_IN:    state_next = S_WR_CLR;
      S_WR_CLR:   state_next = S_PUSH;
      S_PUSH:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so the ports line up with it
  always_comb begin
    req_d  = 1'b0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    addr_d = '0;
    dout_d = 8'h00;
    case (state_next)
      S_REQ: begin
        req_d = 1'b1;
      end
      S_RD_FLAGS: begin
        req_d  = 1'b1;
        rd_d   = 1'b1;
        addr_d = FLAGS_ADDR;
      end
      S_RD_IN: begin
        req_d  = 1'b1;
        rd_d   = 1'b1;
        addr_d = IN_ADDR;
      end
      S_WR_CLR: begin
        req_d  = 1'b1;
        wr_d   = 1'b1;
        addr_d = FLAGS_ADDR;
        dout_d = flags_q;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Bus output registers; reset drops the request and any strobe at once
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_req  <= 1'b0;
      m_rd   <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_dout <= 8'h00;
    end else begin
      m_req  <= req_d;
      m_rd   <= rd_d;
      m_wr   <= wr_d;
      m_addr <= addr_d;
      m_dout <= dout_d;
    end
  end

  // Capture read data in the cycle the read strobe is on the bus
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= 8'h00;
      pins_q  <= 8'h00;
    end else begin
      if (state == S_RD_FLAGS) flags_q <= m_din;
      if (state == S_RD_IN)    pins_q  <= m_din;
    end
  end

  // FIFO control: a pop frees a slot for a same-cycle push even when full
  always_comb begin
    push_req  = (state == S_PUSH);
    push_data = '{pins: pins_q, flags: flags_q};
    full      = (ev_count == CW'(DEPTH));
    pop       = ev_valid && ev_ready;
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;

    wr_ptr_next = push ? (wr_ptr + PW'(1)) : wr_ptr;
    rd_ptr_next = pop  ? (rd_ptr + PW'(1)) : rd_ptr;

    case ({push, pop})
      2'b10:   count_next = ev_count + CW'(1);
      2'b01:   count_next = ev_count - CW'(1);
      default: count_next = ev_count;
    endcase
  end

  // Head entry after this cycle's push/pop; bypass when the push lands at the head
  always_comb begin
    if (count_next == '0) begin
      head_next = '0;
    end else if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      ev_valid <= 1'b0;
      ev_data  <= 16'h0000;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      ev_count <= count_next;
      ev_valid <= (count_next != '0);
      ev_data  <= head_next;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
